// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pkg
//  Description : Shared widths, FSM encoding, round-constant helper and
//                linear-layer rotation amounts for the unrolled Ascon
//                permutation.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

   localparam int STATE_W    = 320;
   localparam int WORD_W     = 64;
   localparam int MAX_ROUNDS = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Linear-layer rotate-right amounts, two per word.
   localparam int ROT_X0_A = 19;
   localparam int ROT_X0_B = 28;
   localparam int ROT_X1_A = 61;
   localparam int ROT_X1_B = 39;
   localparam int ROT_X2_A = 1;
   localparam int ROT_X2_B = 6;
   localparam int ROT_X3_A = 10;
   localparam int ROT_X3_B = 17;
   localparam int ROT_X4_A = 7;
   localparam int ROT_X4_B = 41;

   // Round constant: upper nibble is the complement of the index.
   function automatic logic [7:0] rc(input logic [3:0] idx);
      return {4'd15 - idx, idx};
   endfunction

   function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_round
//  Description : One combinational Ascon round (constant addition, bitsliced
//                5-bit S-box, linear diffusion). With i_en low the state
//                passes through untouched, which lets the unrolled chain
//                bypass rounds not needed in a partial final cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_round
   import ascon_pkg::*;
(
   input  logic [STATE_W-1:0] i_state,
   input  logic [7:0]         i_rc,
   input  logic               i_en,
   output logic [STATE_W-1:0] o_state
);

   logic [WORD_W-1:0] w_a0, w_a1, w_a2, w_a3, w_a4;
   logic [WORD_W-1:0] w_t0, w_t1, w_t2, w_t3, w_t4;
   logic [WORD_W-1:0] w_b0, w_b1, w_b2, w_b3, w_b4;
   logic [WORD_W-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;

   // Constant addition, S-box layer, linear layer, then the bypass mux.
   always_comb begin
      // Constant addition folded into the S-box input XORs.
      w_a0 = i_state[319:256] ^ i_state[63:0];
      w_a1 = i_state[255:192];
      w_a2 = (i_state[191:128] ^ {56'd0, i_rc}) ^ i_state[255:192];
      w_a3 = i_state[127:64];
      w_a4 = i_state[63:0] ^ i_state[127:64];

      w_t0 = ~w_a0 & w_a1;
      w_t1 = ~w_a1 & w_a2;
      w_t2 = ~w_a2 & w_a3;
      w_t3 = ~w_a3 & w_a4;
      w_t4 = ~w_a4 & w_a0;

      w_b0 = w_a0 ^ w_t1;
      w_b1 = w_a1 ^ w_t2;
      w_b2 = w_a2 ^ w_t3;
      w_b3 = w_a3 ^ w_t4;
      w_b4 = w_a4 ^ w_t0;

      w_s1 = w_b1 ^ w_b0;
      w_s0 = w_b0 ^ w_b4;
      w_s3 = w_b3 ^ w_b2;
      w_s2 = ~w_b2;
      w_s4 = w_b4;

      if (i_en) begin
         o_state = {w_s0 ^ ror(w_s0, ROT_X0_A) ^ ror(w_s0, ROT_X0_B),
                    w_s1 ^ ror(w_s1, ROT_X1_A) ^ ror(w_s1, ROT_X1_B),
                    w_s2 ^ ror(w_s2, ROT_X2_A) ^ ror(w_s2, ROT_X2_B),
                    w_s3 ^ ror(w_s3, ROT_X3_A) ^ ror(w_s3, ROT_X3_B),
                    w_s4 ^ ror(w_s4, ROT_X4_A) ^ ror(w_s4, ROT_X4_B)};
      end else begin
         o_state = i_state;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ascon_perm_unrolled.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_perm_unrolled
//  Description : Ascon permutation p^r, r = 0..12 (larger values clamp to 12),
//                UNROLL rounds per clock, integrated round counter and
//                start/done handshake. Round constants are offset so that an
//                r-round run uses the last r constants of RC_BASE.
//                Optional macro ASCON_PERM_CTR_EN exposes the round counter
//                on port ctr.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_perm_unrolled
   import ascon_pkg::*;
#(
   parameter int UNROLL  = 1,
   parameter int RC_BASE = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         rounds,
   input  logic [STATE_W-1:0] S,
   output logic [STATE_W-1:0] out,
   output logic               done,
   output logic               busy
`ifdef ASCON_PERM_CTR_EN
   ,
   output logic [3:0]         ctr
`endif
);

   state_e             fsm_q, fsm_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] out_q, out_d;
   logic [3:0]         r_q, r_d;
   logic [3:0]         i_q, i_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [3:0]         w_r_clamp;
   logic [4:0]         w_adv;
   logic [STATE_W-1:0] w_last;

   assign w_r_clamp = (rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds;
   assign w_adv     = {1'b0, i_q} + 5'(UNROLL);

   // Chain of UNROLL rounds; stages beyond the requested count are bypassed.
   for (genvar j = 0; j < UNROLL; j++) begin : g_round
      logic [STATE_W-1:0] w_in;
      logic [STATE_W-1:0] w_out;
      logic [4:0]         w_pos;
      logic               w_en;
      logic [3:0]         w_idx;
      logic [7:0]         w_rc;

      if (j == 0) begin : g_first
         assign w_in = state_q;
      end else begin : g_chain
         assign w_in = g_round[j-1].w_out;
      end

      assign w_pos = {1'b0, i_q} + 5'(j);
      assign w_en  = (w_pos < {1'b0, r_q});
      assign w_idx = 4'(RC_BASE) - r_q + w_pos[3:0];
      assign w_rc  = rc(w_idx);

      ascon_round u_round (
         .i_state (w_in),
         .i_rc    (w_rc),
         .i_en    (w_en),
         .o_state (w_out)
      );
   end

   assign w_last = g_round[UNROLL-1].w_out;

   // Next-state logic for the IDLE/RUN/DONE controller and datapath registers.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      out_d   = out_q;
      r_d     = r_q;
      i_d     = i_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (fsm_q)
         IDLE: begin
            i_d = 4'd0;
            if (start) begin
               state_d = S;
               r_d     = w_r_clamp;
               if (w_r_clamp == 4'd0) begin
                  fsm_d  = DONE;
                  out_d  = S;
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end else begin
                  fsm_d  = RUN;
                  busy_d = 1'b1;
               end
            end
         end
         RUN: begin
            state_d = w_last;
            if (w_adv >= {1'b0, r_q}) begin
               i_d    = r_q;
               fsm_d  = DONE;
               out_d  = w_last;
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               i_d = w_adv[3:0];
            end
         end
         DONE: begin
            fsm_d  = IDLE;
            i_d    = 4'd0;
            busy_d = 1'b0;
         end
         default: begin
            fsm_d  = IDLE;
            i_d    = 4'd0;
            busy_d = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         out_q   <= '0;
         r_q     <= 4'd0;
         i_q     <= 4'd0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         out_q   <= out_d;
         r_q     <= r_d;
         i_q     <= i_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = busy_q;

`ifdef ASCON_PERM_CTR_EN
   assign ctr = i_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_unrolled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_perm_unrolled
//  Description : Scoreboard bench for ascon_perm_unrolled. Four instances with
//                UNROLL = 1..4 share clock and reset. Expected results come
//                from a table-driven S-box reference model in this file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_unrolled;

   localparam int NDUT = 4;

   localparam logic [319:0] S0 =
      320'hb1052995b8707739d6d42cbb78bb010af1c1629ec1ff700bda64243d428eb536db31c36d00000000;
   localparam logic [319:0] S1 =
      320'h0123456789abcdef_fedcba9876543210_0000000000000000_ffffffffffffffff_8000000000000001;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   typedef struct {
      logic [319:0] out;
      int           lat;
      int           t0;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_v  [NDUT];
   logic [3:0]   rounds_v [NDUT];
   logic [319:0] s_v      [NDUT];
   logic [319:0] out_v    [NDUT];
   logic         done_v   [NDUT];
   logic         busy_v   [NDUT];
`ifdef ASCON_PERM_CTR_EN
   logic [3:0]   ctr_v    [NDUT];
`endif

   exp_t sb [NDUT][$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ascon_perm_unrolled #(.UNROLL(g + 1), .RC_BASE(12)) u_dut (
         .clk    (clk),
         .rst    (rst),
         .start  (start_v[g]),
         .rounds (rounds_v[g]),
         .S      (s_v[g]),
         .out    (out_v[g]),
         .done   (done_v[g]),
         .busy   (busy_v[g])
`ifdef ASCON_PERM_CTR_EN
         ,
         .ctr    (ctr_v[g])
`endif
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      logic [127:0] d;
      d = {v, v} >> n;
      return d[63:0];
   endfunction

   function automatic logic [319:0] model_round(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  col;
      logic [4:0]  v;
      for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
      x[2] = x[2] ^ {56'd0, c};
      for (int b = 0; b < 64; b++) begin
         col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
         v   = SBOX[col];
         for (int w = 0; w < 5; w++) y[w][b] = v[4-w];
      end
      return {y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28),
              y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39),
              y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6),
              y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17),
              y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41)};
   endfunction

   function automatic int eff_rounds(input logic [3:0] r);
      return (r > 4'd12) ? 12 : int'(r);
   endfunction

   function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [3:0] r);
      logic [319:0] st;
      int           n;
      n  = eff_rounds(r);
      st = s;
      for (int i = 0; i < n; i++) st = model_round(st, 8'hf0 - 8'(15 * (12 - n + i)));
      return st;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT pulses done.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int d = 0; d < NDUT; d++) begin
            if (done_v[d] === 1'b1) begin
               if (sb[d].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL u%0d_unexpected_done actual=1 expected=0", d + 1);
               end else begin
                  mon_e = sb[d].pop_front();
                  chk($sformatf("u%0d_out", d + 1), out_v[d], mon_e.out);
                  chk($sformatf("u%0d_latency", d + 1), 320'(cyc - mon_e.t0), 320'(mon_e.lat));
                  chk($sformatf("u%0d_busy_at_done", d + 1), 320'(busy_v[d]), 320'(0));
               end
            end
         end
      end
   end

   // Issue one operation; pushes the expected response when completion is expected.
   task automatic issue(input int d, input logic [3:0] r, input logic [319:0] s, input bit expect_done);
      exp_t e;
      int   n;
      @(negedge clk);
      start_v[d]  = 1'b1;
      rounds_v[d] = r;
      s_v[d]      = s;
      @(posedge clk);
      #1;
      start_v[d]  = 1'b0;
      rounds_v[d] = 4'd3;
      s_v[d]      = ~s;
      n = eff_rounds(r);
      if (expect_done) begin
         e.out = model_perm(s, r);
         e.lat = (n + d) / (d + 1);
         e.t0  = cyc;
         sb[d].push_back(e);
      end
      chk($sformatf("u%0d_busy_after_accept_r%0d", d + 1, r), 320'(busy_v[d]), 320'(n > 0));
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (sb[d].size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb[d].size() != 0) begin
         checks++;
         failures++;
         $display("FAIL u%0d_done_timeout actual=pending%0d expected=pending0", d + 1, sb[d].size());
         sb[d].delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         start_v[d]  = 1'b0;
         rounds_v[d] = 4'd0;
         s_v[d]      = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("u%0d_reset_out", d + 1), out_v[d], 320'd0);
         chk($sformatf("u%0d_reset_done", d + 1), 320'(done_v[d]), 320'd0);
         chk($sformatf("u%0d_reset_busy", d + 1), 320'(busy_v[d]), 320'd0);
`ifdef ASCON_PERM_CTR_EN
         chk($sformatf("u%0d_reset_ctr", d + 1), 320'(ctr_v[d]), 320'd0);
`endif
      end
      @(negedge clk);
      rst = 1'b1;

      // UNROLL=1, p^12 on the regression vector; busy held for 12 cycles.
      issue(0, 4'd12, S0, 1'b1);
      for (int e = 1; e < 12; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("u1_busy_cycle%0d", e), 320'(busy_v[0]), 320'd1);
      end
      drain(0);

      // UNROLL=4 partial-cycle bypass and RC offsets; UNROLL=3 uneven split.
      issue(3, 4'd6, S0, 1'b1);  drain(3);
      issue(3, 4'd8, S0, 1'b1);  drain(3);
      issue(2, 4'd8, S0, 1'b1);  drain(2);
      issue(0, 4'd8, S0, 1'b1);  drain(0);
      issue(0, 4'd6, S0, 1'b1);  drain(0);

      // Boundaries: r=0 passes S through, r=15 clamps to 12.
      issue(0, 4'd0, S0, 1'b1);  drain(0);
      chk("u1_r0_out_equals_S", out_v[0], S0);
      issue(3, 4'd0, S1, 1'b1);  drain(3);
      issue(0, 4'd15, S0, 1'b1); drain(0);
      issue(3, 4'd15, S1, 1'b1); drain(3);

      // UNROLL=2, p^12 on a second pattern, with the counter trace.
      issue(1, 4'd12, S1, 1'b1);
`ifdef ASCON_PERM_CTR_EN
      for (int e = 0; e <= 7; e++) begin
         chk($sformatf("u2_ctr_step%0d", e), 320'(ctr_v[1]), 320'((e <= 6) ? 2 * e : 0));
         @(posedge clk);
         #1;
      end
`endif
      drain(1);
      issue(2, 4'd6, S1, 1'b1);  drain(2);
      issue(3, 4'd1, S1, 1'b1);  drain(3);

      // start pulsed mid-run must not restart or re-sample.
      issue(0, 4'd12, S0, 1'b1);
      repeat (3) @(negedge clk);
      start_v[0]  = 1'b1;
      rounds_v[0] = 4'd2;
      s_v[0]      = S1;
      @(negedge clk);
      start_v[0]  = 1'b0;
      drain(0);

      // Asynchronous reset in the middle of a run.
      issue(0, 4'd12, S1, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("u1_midrun_reset_out", out_v[0], 320'd0);
      chk("u1_midrun_reset_busy", 320'(busy_v[0]), 320'd0);
      chk("u1_midrun_reset_done", 320'(done_v[0]), 320'd0);
      @(negedge clk);
      rst = 1'b1;
      issue(0, 4'd12, S1, 1'b1); drain(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
